pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Multi-cycle fetch/execute controller that drives the PC register's control inputs (reset, load, inc, in) for the Hack-style CPU.
- Fetches each instruction through a req/ack handshake with instruction memory and latches it.
- Pulses the datapath execute enable, evaluates the jump bits against the ALU flags, then either increments the PC or loads a jump target.
- Sits between the PC register, instruction memory and the A/D/ALU datapath.

Parameters:
- WIDTH, 16, address/data width of PC, jump target and A register.
- FETCH_TIMEOUT, 15, maximum FETCH cycles without imem_ack before a fault. 0 disables the timeout. Legal range 0..255.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  level; high allows instruction sequencing.
- pc  in  WIDTH  current PC register output; used as the fetch address.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  WIDTH  equals pc while imem_req=1, else 0.
- imem_ack  in  1  instr valid this cycle.
- instr  in  16  instruction word.
- ir  out  16  latched instruction.
- exec_en  out  1  one-cycle datapath execute strobe.
- alu_zr  in  1  ALU zero flag, valid while exec_en=1.
- alu_ng  in  1  ALU negative flag, valid while exec_en=1.
- a_reg  in  WIDTH  A register value before the execute write.
- pc_reset  out  1  to PC reset input.
- pc_load  out  1  to PC load input.
- pc_inc  out  1  to PC inc input.
- pc_target  out  WIDTH  to PC in input.
- busy  out  1  high in FETCH, EXEC or UPDATE.
- halted  out  1  sticky; set by self-jump or fault.
- fault  out  1  sticky; set by fetch timeout.

Behaviour:
- States, 3-bit encoding: BOOT=0, IDLE=1, FETCH=2, EXEC=3, UPDATE=4. Outputs are Moore-decoded from the state and internal registers.
- Reset low (asynchronous): state=BOOT; ir=0; target register=0; take flag=0; timeout counter=0; halted=0; fault=0.
  - Outputs during reset: pc_reset=1; imem_req, exec_en, pc_load, pc_inc, busy all 0; pc_target=0; imem_addr=0.
- BOOT: pc_reset=1. Next edge after reset releases -> IDLE. This guarantees the PC is 0 before the first fetch.
- IDLE: all strobes 0. Goes to FETCH when run=1 and halted=0; otherwise stays. run is ignored while halted=1.
- FETCH:
  - imem_req=1 and imem_addr=pc for every FETCH cycle.
  - On a cycle with imem_ack=1: ir<=instr, counter<=0, -> EXEC. Minimum fetch latency is 1 cycle.
  - Otherwise the counter increments.
  - If FETCH_TIMEOUT!=0 and the counter reaches FETCH_TIMEOUT-1 with no ack: fault<=1, halted<=1, -> IDLE.
  - An ack on the FETCH_TIMEOUT-th cycle is still accepted; ack has priority over the timeout.
- EXEC: exec_en=1 for exactly one cycle. At the end of the cycle capture:
  - target<=a_reg. This is the pre-write A, matching Hack jump semantics.
  - take<=ir[15] & ((ir[2]&alu_ng) | (ir[1]&alu_zr) | (ir[0]&~alu_ng&~alu_zr)).
  - A-instructions (ir[15]=0) never jump.
  - Then -> UPDATE.
- UPDATE:
  - If take=1: pc_load=1 and pc_target=target.
  - If take=0: pc_inc=1 and pc_target=0.
  - pc_load and pc_inc are never both 1; pc_reset is 0 outside BOOT.
  - Self-jump: take=1 and target==pc -> halted<=1, -> IDLE. The load is still issued.
  - Otherwise, run=1 -> FETCH; run=0 -> IDLE.
- run falling in FETCH or EXEC does not abort; the current instruction completes through UPDATE.
- Throughput: 3 cycles per instruction with zero-wait memory (FETCH, EXEC, UPDATE).
- PC wrap: pc_inc at pc=16'hFFFF is legal. The PC wraps to 0; the sequencer takes no special action.
- Reset asserted mid-operation: immediate return to BOOT with all outputs at their reset values. An in-flight ack is discarded.

Decomposition:
- Shared package/include: state encodings; JLT/JEQ/JGT bit indices (2/1/0); C-instruction bit index 15.
- One natural sub-module: jump_cond, a combinational evaluator of (ir[2:0], zr, ng) -> take. It is reused by any future pipelined controller.

Test Plan:
- Hold reset low 3 cycles, then release: pc_reset=1 throughout and on the first edge after release, then 0; state IDLE; halted=0, fault=0.
- run=1, pc=0, ack on the first FETCH cycle with instr=16'h0007: ir=0007; exec_en high exactly 1 cycle; next cycle pc_inc=1, pc_load=0; next FETCH starts at pc=1, 3 cycles after the first.
- instr=16'hE302 (D;JEQ), pc=5, a_reg=16'h0010, alu_zr=1: UPDATE has pc_load=1, pc_target=16'h0010. Repeat with zr=0, ng=0: pc_inc=1, pc_load=0.
- instr=16'hEA87 (0;JMP), pc=4, a_reg=4: pc_load=1, halted=1, state IDLE. run held at 1 produces no further imem_req until reset.
- FETCH_TIMEOUT=15 with imem_ack held 0: imem_req high 15 cycles, then fault=1, halted=1, imem_req=0. An ack on the 15th cycle instead yields a normal EXEC and fault=0.
- Reset driven low during EXEC: exec_en drops to 0 and pc_reset goes to 1 in the same cycle, before the next clock edge. After release the sequence restarts from BOOT with ir=0.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the Hack-style fetch/execute sequencer:
// state encoding, jump-bit positions and the fetch timeout counter width.
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_FETCH  = 3'd2,
    ST_EXEC   = 3'd3,
    ST_UPDATE = 3'd4
  } seq_state_e;

  localparam int JLT_BIT   = 2;
  localparam int JEQ_BIT   = 1;
  localparam int JGT_BIT   = 0;
  localparam int CINST_BIT = 15;

  localparam int TMO_CNT_W = 8;

endpackage

// File: rtl/pc_sequencer_jump_cond.sv
// Combinational Hack jump evaluator: maps the j1..j3 bits and ALU flags to a
// take/no-take decision. The caller gates it with the C-instruction bit.
module pc_sequencer_jump_cond
  import pc_sequencer_pkg::*;
(
  input  logic [2:0] i_jmp,
  input  logic       i_zr,
  input  logic       i_ng,
  output logic       o_take
);

  assign o_take = (i_jmp[JLT_BIT] & i_ng)
                | (i_jmp[JEQ_BIT] & i_zr)
                | (i_jmp[JGT_BIT] & ~i_ng & ~i_zr);

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/execute controller driving the Hack PC register.
// Handshake: imem_req is held for the whole FETCH state; a cycle with imem_ack=1 transfers instr.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [WIDTH-1:0] pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [15:0]      instr,
  output logic [15:0]      ir,
  output logic             exec_en,
  input  logic             alu_zr,
  input  logic             alu_ng,
  input  logic [WIDTH-1:0] a_reg,
  output logic             pc_reset,
  output logic             pc_load,
  output logic             pc_inc,
  output logic [WIDTH-1:0] pc_target,
  output logic             busy,
  output logic             halted,
  output logic             fault,
  output seq_state_e       dbg_state
);

  localparam bit                 TMO_EN   = (FETCH_TIMEOUT != 0);
  localparam logic [TMO_CNT_W-1:0] TMO_LAST =
    TMO_CNT_W'(TMO_EN ? FETCH_TIMEOUT - 1 : 0);

  seq_state_e           r_state;
  seq_state_e           w_state_nxt;
  logic [15:0]          r_ir;
  logic [WIDTH-1:0]     r_target;
  logic                 r_take;
  logic [TMO_CNT_W-1:0] r_cnt;
  logic                 r_halted;
  logic                 r_fault;

  logic w_ir_load;
  logic w_cnt_inc;
  logic w_cnt_clr;
  logic w_exec_cap;
  logic w_halt_set;
  logic w_fault_set;
  logic w_jump_raw;
  logic w_take;

  pc_sequencer_jump_cond u_jump_cond (
    .i_jmp  (r_ir[2:0]),
    .i_zr   (alu_zr),
    .i_ng   (alu_ng),
    .o_take (w_jump_raw)
  );

  // A-instructions never jump regardless of their low bits.
  assign w_take = r_ir[CINST_BIT] & w_jump_raw;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ir_load   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_cnt_clr   = 1'b0;
    w_exec_cap  = 1'b0;
    w_halt_set  = 1'b0;
    w_fault_set = 1'b0;
    imem_req    = 1'b0;
    imem_addr   = '0;
    exec_en     = 1'b0;
    pc_reset    = 1'b0;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_target   = '0;
    busy        = 1'b0;
    case (r_state)
      ST_BOOT: begin
        pc_reset    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (run && !r_halted) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc;
        busy      = 1'b1;
        // Ack wins over the timeout on the final allowed cycle.
        if (imem_ack) begin
          w_ir_load   = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = ST_EXEC;
        end else if (TMO_EN && (r_cnt == TMO_LAST)) begin
          w_fault_set = 1'b1;
          w_halt_set  = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      ST_EXEC: begin
        exec_en     = 1'b1;
        busy        = 1'b1;
        w_exec_cap  = 1'b1;
        w_state_nxt = ST_UPDATE;
      end
      ST_UPDATE: begin
        busy = 1'b1;
        if (r_take) begin
          pc_load   = 1'b1;
          pc_target = r_target;
        end else begin
          pc_inc = 1'b1;
        end
        // A jump to itself is the Hack idiom for "stop"; the load still goes out.
        if (r_take && (r_target == pc)) begin
          w_halt_set  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (run) begin
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ir     <= '0;
      r_target <= '0;
      r_take   <= 1'b0;
      r_cnt    <= '0;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      if (w_ir_load) r_ir <= instr;
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + TMO_CNT_W'(1);
      end
      if (w_exec_cap) begin
        r_target <= a_reg;
        r_take   <= w_take;
      end
      if (w_halt_set)  r_halted <= 1'b1;
      if (w_fault_set) r_fault  <= 1'b1;
    end
  end

  assign ir        = r_ir;
  assign halted    = r_halted;
  assign fault     = r_fault;
  assign dbg_state = r_state;

endmodule
